counter_sched: RTL and testbench

//  Time-slice scheduler for one shared interval counter. N requesters each ask for
//  the counter with their own interval length. A round-robin arbiter grants one

---
 rtl/counter_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/counter_sched.sv | 132 +++++++++++++
 tb/tb_counter_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types for the interval-counter scheduler: FSM state encoding and pointer sizing.
`timescale 1ns/1ps
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a requester index / round-robin pointer for n requesters.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
`timescale 1ns/1ps
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win_c,
    output logic [PW-1:0] idx_c,
    output logic          any_c
);

    always_comb begin
        logic [PW-1:0] cand;
        cand  = '0;
        win_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = PW'((32'(ptr) + i) % N);
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                idx_c       = cand;
                win_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Time-slice scheduler: round-robin grants one shared down-counter to N requesters.
`timescale 1ns/1ps
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] len,
    input  logic           abort,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic [N-1:0]   done,
    output logic [W-1:0]   value
);

    localparam int unsigned PW = ptr_width(N);

    state_t        state, state_nx;
    logic [PW-1:0] rr_ptr, rr_ptr_nx;
    logic [PW-1:0] owner, owner_nx;
    logic [N-1:0]  gnt_nx, done_nx;
    logic          busy_nx;
    logic [W-1:0]  value_nx;

    logic [N-1:0]  win_c;
    logic [PW-1:0] idx_c;
    logic          any_c;
    logic [PW-1:0] owner_inc_c;
    logic          last_c;
    logic [W-1:0]  len_a [N];

    for (genvar i = 0; i < N; i++) begin : g_len
        assign len_a[i] = len[i*W +: W];
    end

    assign owner_inc_c = (32'(owner) == N - 1) ? '0 : owner + PW'(1);
    assign last_c      = (value <= W'(1));

    rr_arbiter #(.N(N)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .win_c (win_c),
        .idx_c (idx_c),
        .any_c (any_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_c) state_nx = RUN;
            RUN:     if (abort) state_nx = IDLE;
                     else if (last_c) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and the counter datapath.
    always_comb begin
        gnt_nx    = gnt;
        busy_nx   = busy;
        done_nx   = '0;
        value_nx  = value;
        rr_ptr_nx = rr_ptr;
        owner_nx  = owner;
        case (state)
            IDLE: begin
                gnt_nx   = '0;
                busy_nx  = 1'b0;
                value_nx = '0;
                if (any_c) begin
                    gnt_nx   = win_c;
                    busy_nx  = 1'b1;
                    value_nx = len_a[idx_c];
                    owner_nx = idx_c;
                end
            end
            RUN: begin
                if (abort) begin
                    gnt_nx    = '0;
                    busy_nx   = 1'b0;
                    value_nx  = '0;
                    rr_ptr_nx = owner_inc_c;
                end else if (last_c) begin
                    gnt_nx   = '0;
                    done_nx  = gnt;
                    value_nx = '0;
                end else begin
                    value_nx = value - W'(1);
                end
            end
            DONE: begin
                gnt_nx    = '0;
                busy_nx   = 1'b0;
                rr_ptr_nx = owner_inc_c;
            end
            default: begin
                gnt_nx   = '0;
                busy_nx  = 1'b0;
                value_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt    <= '0;
            busy   <= 1'b0;
            done   <= '0;
            value  <= '0;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            gnt    <= gnt_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            value  <= value_nx;
            rr_ptr <= rr_ptr_nx;
            owner  <= owner_nx;
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: timeline model of each grant plus directed literal checks.
`timescale 1ns/1ps
module tb_counter_sched;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           clk   = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] len   = '0;
    logic           abort = 1'b0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [N-1:0]   done;
    logic [W-1:0]   value;

    int errors = 0;
    int checks = 0;

    always #1 clk = ~clk;

    counter_sched #(.W(W), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .abort (abort),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .value (value)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         busy;
        logic [N-1:0] done;
        logic [W-1:0] value;
    } obs_t;

    // Model: on each grant, lay out the whole expected output timeline in a queue.
    obs_t q[$];
    obs_t cur       = '0;
    int   ptr       = 0;
    int   owner     = 0;
    int   grants_ok = 0;
    int   dones_seen = 0;

    always @(posedge clk or negedge reset) begin
        int k, l, n;
        obs_t e;
        if (!reset) begin
            q.delete();
            cur = '0;
            ptr = 0;
        end else if (cur.gnt != 0 && abort) begin
            q.delete();
            cur = '0;
            ptr = (owner + 1) % N;
            grants_ok--;
        end else if (cur == '0) begin
            if (req != 0) begin
                k = -1;
                for (int i = 0; i < N; i++)
                    if (k < 0 && req[(ptr + i) % N]) k = (ptr + i) % N;
                l = int'(len[k*W +: W]);
                n = (l == 0) ? 1 : l;
                for (int i = 0; i < n; i++) begin
                    e = '0;
                    e.gnt   = N'(1 << k);
                    e.busy  = 1'b1;
                    e.value = W'(l - i);
                    q.push_back(e);
                end
                e = '0;
                e.busy = 1'b1;
                e.done = N'(1 << k);
                q.push_back(e);
                owner = k;
                grants_ok++;
                cur = q.pop_front();
            end
        end else if (q.size() == 0) begin
            cur = '0;
            ptr = (owner + 1) % N;
        end else begin
            cur = q.pop_front();
        end
    end

    // Every-cycle comparison against the model plus structural invariants.
    always @(negedge clk) begin
        checks++;
        if ({gnt, busy, done, value} !== cur) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got gnt=%b busy=%b done=%b value=%0d want gnt=%b busy=%b done=%b value=%0d",
                     $time, gnt, busy, done, value, cur.gnt, cur.busy, cur.done, cur.value);
        end
        checks++;
        if (!$onehot0(gnt) || !$onehot0(done) || (gnt & done) != 0) begin
            errors++;
            $display("FAIL invariant t=%0t got gnt=%b done=%b want one-hot-or-zero and disjoint", $time, gnt, done);
        end
        if (done != 0) dones_seen++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, exp);
        end
    endtask

    task automatic set_len(input int i, input int v);
        len[i*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        #0.5 reset = 1'b0;
        req   = '0;
        abort = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        tick(3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_value", 32'(value), 32'h0);
        reset = 1'b1;
        tick(1);

        // Single requester, len 5.
        set_len(1, 5);
        req = 4'b0010;
        tick(1);
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_v5", 32'(value), 32'd5);
        for (int i = 1; i < 5; i++) begin
            tick(1);
            chk("t1_val", 32'(value), 32'(5 - i));
            chk("t1_gnt_hold", 32'(gnt), 32'h2);
        end
        tick(1);
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_done_gnt", 32'(gnt), 32'h0);
        chk("t1_done_busy", 32'(busy), 32'h1);
        req = '0;
        tick(1);
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_done", 32'(done), 32'h0);

        // All four requesting, len 2 each: grant order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 2);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick(1);
            chk("t2_gnt", 32'(gnt), 32'(1 << order[g]));
            chk("t2_v2", 32'(value), 32'd2);
            tick(1);
            chk("t2_v1", 32'(value), 32'd1);
            tick(1);
            chk("t2_done", 32'(done), 32'(1 << order[g]));
            tick(1);
            chk("t2_gap", 32'(gnt), 32'h0);
            if (g == 4) req = '0;
        end

        // len 0 behaves like len 1.
        do_reset();
        set_len(2, 0);
        req = 4'b0100;
        tick(1);
        chk("t3_gnt", 32'(gnt), 32'h4);
        tick(1);
        chk("t3_done", 32'(done), 32'h4);
        chk("t3_gnt_off", 32'(gnt), 32'h0);
        req = '0;
        tick(1);
        chk("t3_idle", 32'(busy), 32'h0);

        // Abort on the third RUN cycle, then round robin moves to requester 1.
        do_reset();
        set_len(0, 10);
        set_len(1, 3);
        req = 4'b0011;
        tick(1);
        chk("t4_gnt0", 32'(gnt), 32'h1);
        tick(2);
        chk("t4_v8", 32'(value), 32'd8);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t4_gnt_drop", 32'(gnt), 32'h0);
        chk("t4_no_done", 32'(done), 32'h0);
        chk("t4_value0", 32'(value), 32'h0);
        chk("t4_busy0", 32'(busy), 32'h0);
        tick(1);
        chk("t4_gnt1", 32'(gnt), 32'h2);
        chk("t4_v3", 32'(value), 32'd3);
        req = '0;
        tick(3);
        chk("t4_done1", 32'(done), 32'h2);
        tick(1);

        // Reset asserted mid-RUN clears everything immediately.
        do_reset();
        set_len(1, 9);
        req = 4'b0010;
        tick(3);
        chk("t5_v7", 32'(value), 32'd7);
        #0.5 reset = 1'b0;
        #0.2;
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_done", 32'(done), 32'h0);
        chk("t5_value", 32'(value), 32'h0);
        tick(1);
        set_len(3, 4);
        req   = 4'b1000;
        reset = 1'b1;
        tick(1);
        chk("t5_gnt3", 32'(gnt), 32'h8);
        chk("t5_v4", 32'(value), 32'd4);
        tick(4);
        chk("t5_done3", 32'(done), 32'h8);
        req = '0;
        tick(1);

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        grants_ok  = 0;
        dones_seen = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            for (int i = 0; i < N; i++) set_len(i, int'($urandom_range(0, 6)));
            abort = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        req   = '0;
        abort = 1'b0;
        tick(12);
        chk("rand_done_count", 32'(dones_seen), 32'(grants_ok));
        chk("rand_activity", 32'(grants_ok > 100), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
